// File: rtl/dct_pkg.sv
// Shared constants, row types and pixel saturation for the 8x8 inverse DCT.
package dct_pkg;

    localparam int COEF_W = 16;
    localparam int PIX_W  = 8;
    localparam int N      = 8;

    typedef logic signed [COEF_W-1:0] coef_row_t [N];
    typedef logic        [PIX_W-1:0]  pix_row_t  [N];

    typedef enum logic {
        BANK_FREE = 1'b0,
        BANK_FULL = 1'b1
    } bank_state_t;

    // Clamp a signed value into the unsigned range 0 .. 2^pix_w-1.
    function automatic int sat_pix(input int v, input int pix_w);
        int top;
        int r;
        top = (1 << pix_w) - 1;
        r   = v;
        if (v < 0) begin
            r = 0;
        end else if (v > top) begin
            r = top;
        end
        return r;
    endfunction

endpackage

// File: rtl/idct_1d.sv
// Combinational 8-point inverse transform built from shift/add lifting steps
// and halving butterflies. Halved sums keep one extra bit; everything else wraps.
module idct_1d #(
    parameter int W = dct_pkg::COEF_W
) (
    input  logic signed [W-1:0] y [dct_pkg::N],
    output logic signed [W-1:0] x [dct_pkg::N]
);

    typedef logic signed [W-1:0] val_t;
    typedef logic signed [W:0]   wide_t;

    // (p + q) / 2 with the sum held at W+1 bits so the carry is not lost.
    function automatic val_t half_sum(input val_t p, input val_t q);
        wide_t s;
        s = wide_t'(p) + wide_t'(q);
        return val_t'(s >>> 1);
    endfunction

    // (p - q) / 2 with the difference held at W+1 bits.
    function automatic val_t half_diff(input val_t p, input val_t q);
        wide_t s;
        s = wide_t'(p) - wide_t'(q);
        return val_t'(s >>> 1);
    endfunction

    val_t b0, b1, b2, b3, b4, b5, b6, b7;
    val_t a0, a1, a2, a3, a4, a5, a6, a7;
    val_t t5, t6;

    // Lifting stages, inner butterflies, rotation, then output butterflies.
    always_comb begin
        b7 = y[7];
        b4 = (b7 >>> 3) - y[4];
        b6 = (y[5] >>> 1) - y[6];
        b5 = y[5] - ((b6 >>> 3) + (b6 >>> 2) + (b6 >>> 1));
        b3 = y[3] - ((y[2] >>> 3) + (y[2] >>> 2));
        b2 = ((b3 >>> 3) + (b3 >>> 2)) - y[2];
        b1 = (y[0] >>> 1) - y[1];
        b0 = y[0] - b1;

        a0 = half_sum(b0, b3);
        a3 = half_diff(b0, b3);
        a1 = half_sum(b1, b2);
        a2 = half_diff(b1, b2);
        a4 = half_sum(b4, b5);
        t5 = half_diff(b4, b5);
        a7 = half_sum(b6, b7);
        t6 = half_diff(b7, b6);
        a5 = ((t6 >>> 3) + (t6 >>> 2) + (t6 >>> 2)) - t5;
        a6 = t6 - ((a5 >>> 3) + (a5 >>> 2));

        x[0] = half_sum(a0, a7);
        x[7] = half_diff(a0, a7);
        x[1] = half_sum(a1, a6);
        x[6] = half_diff(a1, a6);
        x[2] = half_sum(a2, a5);
        x[5] = half_diff(a2, a5);
        x[3] = half_sum(a3, a4);
        x[4] = half_diff(a3, a4);
    end

endmodule

// File: rtl/idct_8x8.sv
// 2-D 8x8 inverse DCT: row pass on input, ping-pong transpose banks,
// column pass with saturation on output. Streams one row in / one column out per beat.
module idct_8x8 #(
    parameter int COEF_W = dct_pkg::COEF_W,
    parameter int PIX_W  = dct_pkg::PIX_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [COEF_W-1:0] s_data [dct_pkg::N],
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic        [PIX_W-1:0]  m_data [dct_pkg::N]
);

    import dct_pkg::N;
    import dct_pkg::bank_state_t;
    import dct_pkg::BANK_FREE;
    import dct_pkg::BANK_FULL;
    import dct_pkg::sat_pix;

    logic signed [COEF_W-1:0] mem [2][N][N];
    logic signed [COEF_W-1:0] row_out [N];
    logic signed [COEF_W-1:0] col_in  [N];
    logic signed [COEF_W-1:0] col_out [N];

    bank_state_t bank_state [2];
    logic        wr_bank;
    logic        rd_bank;
    logic [2:0]  wr_row;
    logic [2:0]  rd_col;
    logic        wr_en;
    logic        rd_load;

    idct_1d #(.W(COEF_W)) u_row_pass (
        .y (s_data),
        .x (row_out)
    );

    idct_1d #(.W(COEF_W)) u_col_pass (
        .y (col_in),
        .x (col_out)
    );

    assign s_ready = (bank_state[wr_bank] == BANK_FREE);
    assign wr_en   = s_valid && s_ready;
    assign rd_load = (bank_state[rd_bank] == BANK_FULL) && (!m_valid || m_ready);

    // Transposed read: gather one column of the bank being drained.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            col_in[k] = mem[rd_bank][k][rd_col];
        end
    end

    // Store the row-transformed input; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < N; k++) begin
                mem[wr_bank][wr_row][k] <= row_out[k];
            end
        end
    end

    // Bank ownership, fill/drain pointers and the registered output beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_state[0] <= BANK_FREE;
            bank_state[1] <= BANK_FREE;
            wr_bank       <= 1'b0;
            wr_row        <= 3'd0;
            rd_bank       <= 1'b0;
            rd_col        <= 3'd0;
            m_valid       <= 1'b0;
            for (int k = 0; k < N; k++) begin
                m_data[k] <= '0;
            end
        end else begin
            if (wr_en) begin
                wr_row <= wr_row + 3'd1;
                if (wr_row == 3'd7) begin
                    bank_state[wr_bank] <= BANK_FULL;
                    wr_bank             <= ~wr_bank;
                end
            end

            if (rd_load) begin
                for (int k = 0; k < N; k++) begin
                    m_data[k] <= PIX_W'(sat_pix(int'(col_out[k]), PIX_W));
                end
                rd_col <= rd_col + 3'd1;
                if (rd_col == 3'd7) begin
                    bank_state[rd_bank] <= BANK_FREE;
                    rd_bank             <= ~rd_bank;
                end
            end

            if (rd_load) begin
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_idct_8x8.sv
// Directed bench for idct_8x8 with a reference model feeding a scoreboard queue.
module tb_idct_8x8;

    localparam int COEF_W = 16;
    localparam int PIX_W  = 8;
    localparam int LIMIT  = 300;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     s_valid;
    logic                     s_ready;
    logic signed [COEF_W-1:0] s_data [8];
    logic                     m_valid;
    logic                     m_ready;
    logic        [PIX_W-1:0]  m_data [8];

    always #5 clk = ~clk;

    idct_8x8 #(.COEF_W(COEF_W), .PIX_W(PIX_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [8*PIX_W-1:0] exp_q [$];
    int stim [8][8];
    int blk  [8][8];
    int in_row = 0;
    int const_exp = -1;
    int beats_seen = 0;
    bit measure_lat = 0;
    int first_row7 = -1;
    int first_valid = -1;
    int sready_low = 0;
    bit hold_check = 0;
    bit held_set = 0;
    logic [8*PIX_W-1:0] held_val = '0;
    int stable_bad = 0;

    function automatic int wrap(input int v);
        int r;
        r = v & ((1 << COEF_W) - 1);
        if (r >= (1 << (COEF_W - 1))) r = r - (1 << COEF_W);
        return r;
    endfunction

    function automatic int hs(input int p, input int q);
        return wrap((p + q) >>> 1);
    endfunction

    function automatic int hd(input int p, input int q);
        return wrap((p - q) >>> 1);
    endfunction

    function automatic int sat(input int v);
        int r;
        r = v;
        if (v < 0) r = 0;
        else if (v > (1 << PIX_W) - 1) r = (1 << PIX_W) - 1;
        return r;
    endfunction

    task automatic idct_ref(input int y [8], output int x [8]);
        int b0, b1, b2, b3, b4, b5, b6, b7;
        int a0, a1, a2, a3, a4, a5, a6, a7, t5, t6;
        b7 = y[7];
        b4 = wrap((b7 >>> 3) - y[4]);
        b6 = wrap((y[5] >>> 1) - y[6]);
        b5 = wrap(y[5] - ((b6 >>> 3) + (b6 >>> 2) + (b6 >>> 1)));
        b3 = wrap(y[3] - ((y[2] >>> 3) + (y[2] >>> 2)));
        b2 = wrap(((b3 >>> 3) + (b3 >>> 2)) - y[2]);
        b1 = wrap((y[0] >>> 1) - y[1]);
        b0 = wrap(y[0] - b1);
        a0 = hs(b0, b3); a3 = hd(b0, b3);
        a1 = hs(b1, b2); a2 = hd(b1, b2);
        a4 = hs(b4, b5); t5 = hd(b4, b5);
        a7 = hs(b6, b7); t6 = hd(b7, b6);
        a5 = wrap(((t6 >>> 3) + (t6 >>> 2) + (t6 >>> 2)) - t5);
        a6 = wrap(t6 - ((a5 >>> 3) + (a5 >>> 2)));
        x[0] = hs(a0, a7); x[7] = hd(a0, a7);
        x[1] = hs(a1, a6); x[6] = hd(a1, a6);
        x[2] = hs(a2, a5); x[5] = hd(a2, a5);
        x[3] = hs(a3, a4); x[4] = hd(a3, a4);
    endtask

    task automatic push_block();
        int rows_out [8][8];
        int y  [8];
        int xo [8];
        logic [8*PIX_W-1:0] beat;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) y[k] = blk[r][k];
            idct_ref(y, xo);
            for (int k = 0; k < 8; k++) rows_out[r][k] = xo[k];
        end
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 8; k++) y[k] = rows_out[k][c];
            idct_ref(y, xo);
            for (int k = 0; k < 8; k++) begin
                if (const_exp >= 0) beat[k*PIX_W +: PIX_W] = PIX_W'(const_exp);
                else                beat[k*PIX_W +: PIX_W] = PIX_W'(sat(xo[k]));
            end
            exp_q.push_back(beat);
        end
    endtask

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input logic [8*PIX_W-1:0] got);
        logic [8*PIX_W-1:0] exp;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL beat_unexpected observed=%0h expected=none", got);
        end
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            checks++;
            assert (got === exp) else begin
                errors++;
                $error("FAIL beat observed=%0h expected=%0h", got, exp);
            end
        end
    endtask

    function automatic logic [8*PIX_W-1:0] packed_out();
        logic [8*PIX_W-1:0] v;
        for (int k = 0; k < 8; k++) v[k*PIX_W +: PIX_W] = m_data[k];
        return v;
    endfunction

    task automatic observe();
        logic [8*PIX_W-1:0] got;
        if (rst_n) begin
            if (s_valid && !s_ready) sready_low++;
            if (s_valid && s_ready) begin
                for (int k = 0; k < 8; k++) blk[in_row][k] = int'(s_data[k]);
                if (in_row == 7) begin
                    if (measure_lat && first_row7 < 0) first_row7 = cycle;
                    push_block();
                    in_row = 0;
                end else begin
                    in_row++;
                end
            end
            got = packed_out();
            if (measure_lat && m_valid && first_valid < 0) first_valid = cycle;
            if (hold_check && m_valid) begin
                if (!held_set) begin
                    held_set = 1;
                    held_val = got;
                end else if (got !== held_val) begin
                    stable_bad++;
                end
            end
            if (m_valid && m_ready) begin
                beats_seen++;
                check_output(got);
            end
        end
    endtask

    task automatic tick();
        #1;
        observe();
        @(negedge clk);
        cycle++;
    endtask

    task automatic apply_stimulus(input int nrows);
        int waited;
        for (int r = 0; r < nrows; r++) begin
            s_valid = 1'b1;
            for (int k = 0; k < 8; k++) s_data[k] = COEF_W'(stim[r][k]);
            waited = 0;
            while (!s_ready && waited < LIMIT) begin
                tick();
                waited++;
            end
            check_val("send_timeout", 64'(waited < LIMIT), 64'd1);
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        m_ready = 1'b1;
        waited = 0;
        while ((exp_q.size() != 0 || m_valid) && waited < LIMIT) begin
            tick();
            waited++;
        end
        check_val("drain_timeout", 64'(waited < LIMIT), 64'd1);
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        in_row = 0;
    endtask

    task automatic set_dc(input int v);
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) stim[r][k] = 0;
        stim[0][0] = v;
    endtask

    task automatic set_random();
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) stim[r][k] = int'($urandom_range(0, 4095)) - 2048;
        stim[0][0] = stim[0][0] + 4096;
    endtask

    initial begin
        int sready_high;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        for (int k = 0; k < 8; k++) s_data[k] = '0;
        @(negedge clk);

        do_reset();
        check_val("reset_s_ready", 64'(s_ready), 64'd1);
        check_val("reset_m_valid", 64'(m_valid), 64'd0);
        check_val("reset_m_data", packed_out(), 64'd0);

        $display("[TB] all-zero, DC and saturation blocks");
        m_ready = 1'b1;
        set_dc(0);      const_exp = 0;   apply_stimulus(8); drain();
        set_dc(8192);   const_exp = 128; apply_stimulus(8); drain();
        set_dc(-8192);  const_exp = 0;   apply_stimulus(8); drain();
        set_dc(32760);  const_exp = 255; apply_stimulus(8); drain();
        const_exp = -1;

        $display("[TB] back-to-back two blocks");
        measure_lat = 1; first_row7 = -1; first_valid = -1; sready_low = 0; beats_seen = 0;
        set_random(); apply_stimulus(8);
        set_random(); apply_stimulus(8);
        drain();
        measure_lat = 0;
        check_val("b2b_latency", 64'(first_valid - first_row7), 64'd2);
        check_val("b2b_s_ready_low", 64'(sready_low), 64'd0);
        check_val("b2b_beats", 64'(beats_seen), 64'd16);

        $display("[TB] backpressure");
        m_ready = 1'b0;
        set_random(); apply_stimulus(8);
        hold_check = 1; held_set = 0; stable_bad = 0;
        set_random(); apply_stimulus(8);
        set_random();
        s_valid = 1'b1;
        for (int k = 0; k < 8; k++) s_data[k] = COEF_W'(stim[0][k]);
        sready_high = 0;
        for (int i = 0; i < 12; i++) begin
            if (s_ready) sready_high++;
            tick();
        end
        hold_check = 0;
        check_val("bp_block3_blocked", 64'(sready_high), 64'd0);
        check_val("bp_m_valid_held", 64'(m_valid), 64'd1);
        check_val("bp_held_seen", 64'(held_set), 64'd1);
        check_val("bp_m_data_stable", 64'(stable_bad), 64'd0);
        m_ready = 1'b1;
        apply_stimulus(8);
        drain();

        $display("[TB] reset mid-block");
        set_random(); apply_stimulus(5);
        do_reset();
        check_val("midrst_s_ready", 64'(s_ready), 64'd1);
        check_val("midrst_m_valid", 64'(m_valid), 64'd0);
        beats_seen = 0;
        set_random(); apply_stimulus(8);
        drain();
        for (int i = 0; i < 10; i++) tick();
        check_val("midrst_beats", 64'(beats_seen), 64'd8);
        check_val("midrst_idle", 64'(m_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
